// File: rtl/systolic_tile_ctrl_if.sv
// Signal bundle between the tile scheduler / PE-array edge / readout consumer and the tile sequencer.
// master = scheduler/consumer side, slave = systolic_tile_ctrl.
interface systolic_tile_ctrl_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 busy;
  logic                 done;
  logic                 stall;
  logic                 pe_en;
  logic                 pe_clear;
  logic [ROWS-1:0]      a_vld;
  logic [ROWS*KW-1:0]   a_kidx;
  logic [COLS-1:0]      b_vld;
  logic [COLS*KW-1:0]   b_kidx;
  logic                 out_valid;
  logic                 out_ready;
  logic [RW-1:0]        out_row;

  modport master (
    output start, k_len, stall, out_ready,
    input  busy, done, pe_en, pe_clear, a_vld, a_kidx, b_vld, b_kidx, out_valid, out_row
  );

  modport slave (
    input  start, k_len, stall, out_ready,
    output busy, done, pe_en, pe_clear, a_vld, a_kidx, b_vld, b_kidx, out_valid, out_row
  );
endinterface

// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one output tile of a ROWS x COLS systolic MAC array: clear, skewed feed, drain, readout.
// Optional SYSTOLIC_CTRL_PERF_EN adds saturating stall_cnt_o / tile_cnt_o performance counters.
module systolic_tile_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  systolic_tile_ctrl_if.slave  bus
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          tile_cnt_o
`endif
);

  localparam int TW = KW + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    READ  = 3'd4
  } state_e;

  state_e               state_q;
  logic [KW-1:0]        k_len_q;
  logic [TW-1:0]        t_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pe_en_q;
  logic                 pe_clear_q;
  logic [ROWS-1:0]      a_vld_q;
  logic [ROWS*KW-1:0]   a_kidx_q;
  logic [COLS-1:0]      b_vld_q;
  logic [COLS*KW-1:0]   b_kidx_q;
  logic                 out_valid_q;
  logic [RW-1:0]        out_row_q;

  logic [TW-1:0]        t_d;
  logic [ROWS-1:0]      a_vld_d;
  logic [ROWS*KW-1:0]   a_kidx_d;
  logic [COLS-1:0]      b_vld_d;
  logic [COLS*KW-1:0]   b_kidx_d;
  logic [TW-1:0]        k_ext;
  logic [TW-1:0]        t_last;
  logic                 feed_stall;

  // Lane n carries reduction index t-n while that index lies inside 0..k_len-1.
  function automatic logic lane_vld(input logic [TW-1:0] t, input logic [TW-1:0] lane,
                                    input logic [TW-1:0] klen);
    return (t >= lane) && ((t - lane) < klen);
  endfunction

  assign k_ext      = {1'b0, k_len_q};
  assign t_last     = k_ext + TW'(ROWS + COLS - 3);
  assign feed_stall = (state_q == FEED) && bus.stall;

  always_comb begin
    t_d      = (state_q == FEED) ? t_q + TW'(1) : '0;
    a_vld_d  = '0;
    a_kidx_d = '0;
    b_vld_d  = '0;
    b_kidx_d = '0;
    for (int i = 0; i < ROWS; i++) begin
      a_vld_d[i]           = lane_vld(t_d, TW'(i), k_ext);
      a_kidx_d[i*KW +: KW] = a_vld_d[i] ? (t_d[KW-1:0] - KW'(i)) : '0;
    end
    for (int j = 0; j < COLS; j++) begin
      b_vld_d[j]           = lane_vld(t_d, TW'(j), k_ext);
      b_kidx_d[j*KW +: KW] = b_vld_d[j] ? (t_d[KW-1:0] - KW'(j)) : '0;
    end
  end

  // Edge outputs are registered one step ahead so they always describe the current t_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      t_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_en_q     <= 1'b0;
      pe_clear_q  <= 1'b0;
      a_vld_q     <= '0;
      a_kidx_q    <= '0;
      b_vld_q     <= '0;
      b_kidx_q    <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= CLEAR;
            k_len_q    <= bus.k_len;
            busy_q     <= 1'b1;
            pe_en_q    <= 1'b1;
            pe_clear_q <= 1'b1;
          end
        end
        CLEAR: begin
          pe_clear_q <= 1'b0;
          t_q        <= t_d;
          if (k_len_q == '0) begin
            state_q <= DRAIN;
          end else begin
            state_q  <= FEED;
            a_vld_q  <= a_vld_d;
            a_kidx_q <= a_kidx_d;
            b_vld_q  <= b_vld_d;
            b_kidx_q <= b_kidx_d;
          end
        end
        FEED: begin
          if (!bus.stall) begin
            if (t_q == t_last) begin
              state_q  <= DRAIN;
              a_vld_q  <= '0;
              a_kidx_q <= '0;
              b_vld_q  <= '0;
              b_kidx_q <= '0;
            end else begin
              t_q      <= t_d;
              a_vld_q  <= a_vld_d;
              a_kidx_q <= a_kidx_d;
              b_vld_q  <= b_vld_d;
              b_kidx_q <= b_kidx_d;
            end
          end
        end
        DRAIN: begin
          state_q     <= READ;
          pe_en_q     <= 1'b0;
          out_valid_q <= 1'b1;
          out_row_q   <= '0;
        end
        READ: begin
          if (bus.out_ready) begin
            if (out_row_q == RW'(ROWS - 1)) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_row_q   <= '0;
              done_q      <= 1'b1;
            end else begin
              out_row_q <= out_row_q + RW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pe_en     = pe_en_q & ~feed_stall;
  assign bus.pe_clear  = pe_clear_q;
  assign bus.a_vld     = a_vld_q;
  assign bus.a_kidx    = a_kidx_q;
  assign bus.b_vld     = b_vld_q;
  assign bus.b_kidx    = b_kidx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = out_row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] tile_cnt_q;

  // Both counters stick at all-ones and only reset clears them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      tile_cnt_q  <= '0;
    end else begin
      if (feed_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (done_q && (tile_cnt_q != '1)) begin
        tile_cnt_q <= tile_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign tile_cnt_o  = tile_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: a behavioural 4x4 PE array follows the controller outputs and its
// accumulators are compared at readout with a direct matrix product; tile timing comes from a vector table.
module tb_systolic_tile_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 16;
  localparam int RW   = 2;
  localparam int KMAX = 8;

  typedef struct {
    int          kLen;
    int          stallAt;
    int          stallLen;
    logic [15:0] readyPat;
    int          expLatency;
    int          expVldCycles;
    int          expA3Cycles;
  } tileVec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  systolic_tile_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .RW(RW)) bus ();

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] tileCnt;
  systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .RW(RW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .stall_cnt_o(stallCnt), .tile_cnt_o(tileCnt));
`else
  systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .RW(RW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus));
`endif

  int vectors = 0;
  int miscompares = 0;
  int tilesDone = 0;
  int stallTotal = 0;

  longint matA [ROWS][KMAX];
  longint matB [KMAX][COLS];

  // Behavioural PE grid: A moves right, B moves down, one register per hop.
  longint acc [ROWS][COLS];
  longint aR  [ROWS][COLS];
  longint bR  [ROWS][COLS];
  bit     aV  [ROWS][COLS];
  bit     bV  [ROWS][COLS];
  longint mAIn, mBIn;
  bit     mAInV, mBInV;
  int     mKa, mKb;

  always @(negedge clk) begin
    if (rstn && bus.pe_en) begin
      for (int i = ROWS - 1; i >= 0; i--) begin
        for (int j = COLS - 1; j >= 0; j--) begin
          if (j == 0) begin
            mAInV = bus.a_vld[i];
            mKa   = int'(bus.a_kidx[i*KW +: KW]);
            mAIn  = (mAInV && mKa < KMAX) ? matA[i][mKa] : 0;
          end else begin
            mAInV = aV[i][j-1];
            mAIn  = aR[i][j-1];
          end
          if (i == 0) begin
            mBInV = bus.b_vld[j];
            mKb   = int'(bus.b_kidx[j*KW +: KW]);
            mBIn  = (mBInV && mKb < KMAX) ? matB[mKb][j] : 0;
          end else begin
            mBInV = bV[i-1][j];
            mBIn  = bR[i-1][j];
          end
          if (bus.pe_clear) begin
            acc[i][j] = 0;
            aR[i][j]  = 0;
            bR[i][j]  = 0;
            aV[i][j]  = 1'b0;
            bV[i][j]  = 1'b0;
          end else begin
            if (mAInV && mBInV) acc[i][j] = acc[i][j] + mAIn * mBIn;
            aR[i][j] = mAIn;
            bR[i][j] = mBIn;
            aV[i][j] = mAInV;
            bV[i][j] = mBInV;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic longint refAcc(input int r, input int c, input int kLen);
    longint s = 0;
    for (int k = 0; k < kLen; k++) s += matA[r][k] * matB[k][c];
    return s;
  endfunction

  task automatic prepTile(input int kLen);
    for (int i = 0; i < ROWS; i++)
      for (int k = 0; k < KMAX; k++) matA[i][k] = longint'($urandom_range(65535)) - 32768;
    for (int k = 0; k < KMAX; k++)
      for (int j = 0; j < COLS; j++) matB[k][j] = longint'($urandom_range(65535)) - 32768;
    if (kLen > 0) begin
      matA[0][0]             = -32768;
      matB[0][0]             = -32768;
      matA[ROWS-1][kLen-1]   = -32768;
      matB[kLen-1][COLS-1]   = 32767;
    end
  endtask

  // Caller is at #1 after a rising edge; that cycle counts as cycle 0 of the tile.
  task automatic applyStimulus(input tileVec_t v, input bit holdStart);
    int c = 0;
    int readIdx = 0;
    int expRow = 0;
    int vldCycles = 0;
    int a3Cycles = 0;
    int kidxBad = 0;
    int firstStall;
    bit doneSeen = 1'b0;
    bit stalled;
    logic [ROWS-1:0]    pa  = '0;
    logic [ROWS*KW-1:0] pak = '0;
    logic [COLS-1:0]    pb  = '0;
    logic [COLS*KW-1:0] pbk = '0;
    prepTile(v.kLen);
    firstStall    = 2 + v.stallAt;
    bus.k_len     = KW'(v.kLen);
    bus.start     = 1'b1;
    bus.stall     = 1'b0;
    bus.out_ready = 1'b0;
    while (!doneSeen && c < 200) begin
      @(posedge clk);
      #1;
      c++;
      bus.start = holdStart;
      if (bus.done) begin
        doneSeen = 1'b1;
      end else begin
        stalled       = (v.stallLen > 0) && (c >= firstStall) && (c < firstStall + v.stallLen);
        bus.stall     = stalled;
        bus.out_ready = bus.out_valid ? ((readIdx < 16) ? v.readyPat[readIdx] : 1'b1) : 1'b0;
        @(negedge clk);
        if (c == 1) begin
          checkOutput("clearPeClear", bus.pe_clear, 1);
          checkOutput("clearPeEn", bus.pe_en, 1);
          checkOutput("clearBusy", bus.busy, 1);
        end
        if ((|bus.a_vld) || (|bus.b_vld)) vldCycles++;
        if (bus.a_vld[ROWS-1]) a3Cycles++;
        for (int i = 0; i < ROWS; i++)
          if (!bus.a_vld[i] && bus.a_kidx[i*KW +: KW] != '0) kidxBad++;
        for (int j = 0; j < COLS; j++)
          if (!bus.b_vld[j] && bus.b_kidx[j*KW +: KW] != '0) kidxBad++;
        if (stalled) checkOutput("stallPeEn", bus.pe_en, 0);
        if ((v.stallLen > 0) && (c > firstStall) && (c <= firstStall + v.stallLen)) begin
          checkOutput("stallHoldAVld", bus.a_vld, pa);
          checkOutput("stallHoldAKidx", bus.a_kidx, pak);
          checkOutput("stallHoldBVld", bus.b_vld, pb);
          checkOutput("stallHoldBKidx", bus.b_kidx, pbk);
        end
        pa  = bus.a_vld;
        pak = bus.a_kidx;
        pb  = bus.b_vld;
        pbk = bus.b_kidx;
        if (bus.out_valid) begin
          checkOutput("outRow", bus.out_row, expRow);
          if (bus.out_ready && expRow < ROWS) begin
            for (int j = 0; j < COLS; j++)
              checkOutput($sformatf("acc[%0d][%0d]", expRow, j), acc[expRow][j], refAcc(expRow, j, v.kLen));
            expRow++;
          end
          readIdx++;
        end
      end
    end
    if (doneSeen) tilesDone++;
    stallTotal += v.stallLen;
    checkOutput("doneLatency", doneSeen ? c : -1, v.expLatency);
    checkOutput("rowsRead", expRow, ROWS);
    checkOutput("vldCycles", vldCycles, v.expVldCycles);
    checkOutput("aVld3Cycles", a3Cycles, v.expA3Cycles);
    checkOutput("kidxWhenInvalid", kidxBad, 0);
  endtask

  tileVec_t vecs [5];
  int doneCount;

  initial begin
    vecs[0] = '{kLen: 4, stallAt: 0, stallLen: 0, readyPat: 16'hFFFF, expLatency: 17, expVldCycles: 7,  expA3Cycles: 4};
    vecs[1] = '{kLen: 4, stallAt: 5, stallLen: 3, readyPat: 16'hFFFF, expLatency: 20, expVldCycles: 10, expA3Cycles: 7};
    vecs[2] = '{kLen: 0, stallAt: 0, stallLen: 0, readyPat: 16'hFFFF, expLatency: 7,  expVldCycles: 0,  expA3Cycles: 0};
    vecs[3] = '{kLen: 4, stallAt: 0, stallLen: 0, readyPat: 16'hFFF2, expLatency: 20, expVldCycles: 7,  expA3Cycles: 4};
    vecs[4] = '{kLen: 7, stallAt: 0, stallLen: 2, readyPat: 16'hFFFF, expLatency: 22, expVldCycles: 12, expA3Cycles: 7};

    rstn          = 1'b0;
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.stall     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, then five idle cycles with nothing requested.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstPeEn", bus.pe_en, 0);
    checkOutput("rstOutValid", bus.out_valid, 0);
    checkOutput("rstAVld", bus.a_vld, 0);
    checkOutput("rstBVld", bus.b_vld, 0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idleBusy", bus.busy, 0);
    checkOutput("idlePeEn", bus.pe_en, 0);
    checkOutput("idleOutValid", bus.out_valid, 0);
    checkOutput("idleVld", {bus.a_vld, bus.b_vld}, 0);

    // Abort a tile mid-FEED with an asynchronous reset pulse.
    prepTile(4);
    bus.k_len = KW'(4);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checkOutput("preAbortBusy", bus.busy, 1);
    rstn = 1'b0;
    #1;
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortPeEn", bus.pe_en, 0);
    checkOutput("abortVld", {bus.a_vld, bus.b_vld}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    doneCount = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.done) doneCount++;
    end
    checkOutput("abortNoDone", doneCount, 0);
    checkOutput("abortIdle", bus.busy, 0);

    for (int n = 0; n < 5; n++) applyStimulus(vecs[n], 1'b0);

    // start held through a whole tile, and still high on the done cycle, chains straight into the next tile.
    applyStimulus(vecs[0], 1'b1);
    applyStimulus(vecs[2], 1'b0);
    @(posedge clk);
    #1;
    checkOutput("donePulseEnds", bus.done, 0);
    checkOutput("backToIdle", bus.busy, 0);

`ifdef SYSTOLIC_CTRL_PERF_EN
    @(posedge clk);
    #1;
    checkOutput("perfStallCnt", stallCnt, stallTotal);
    checkOutput("perfTileCnt", tileCnt, tilesDone);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
